// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB FS/LS transmit line encoder.
//   - tx_state_e   : encoder FSM states
//   - J_FS/K_FS/J_LS/K_LS/SE0 : line states as {dp, dm}
//   - *_MIN/*_MAX  : legal ranges of the encoder parameters
//   - line_toggle  : NRZI transition between J and K
package usb_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_SE0  = 2'd2,
    ST_EOPJ = 2'd3
  } tx_state_e;

  localparam logic [1:0] J_FS = 2'b10;
  localparam logic [1:0] K_FS = 2'b01;
  localparam logic [1:0] J_LS = 2'b01;
  localparam logic [1:0] K_LS = 2'b10;
  localparam logic [1:0] SE0  = 2'b00;

  localparam int unsigned STUFF_LEN_MIN    = 2;
  localparam int unsigned STUFF_LEN_MAX    = 15;
  localparam int unsigned EOP_SE0_BITS_MIN = 1;
  localparam int unsigned EOP_SE0_BITS_MAX = 4;
  localparam int unsigned EOP_J_BITS_MIN   = 1;
  localparam int unsigned EOP_J_BITS_MAX   = 4;

  // J goes to K; anything else (K) goes back to J.
  function automatic logic [1:0] line_toggle(input logic [1:0] line, input logic low_speed);
    logic [1:0] j;
    logic [1:0] k;
    j = low_speed ? J_LS : J_FS;
    k = low_speed ? K_LS : K_FS;
    return (line == j) ? k : j;
  endfunction

endpackage

// File: rtl/usb_tx_bitcnt.sv
// Loadable saturating up-counter with a terminal-count compare.
//   clk, n_rst : clock, async active-low reset (count resets to 0)
//   load       : load load_val (has priority over inc)
//   load_val   : value loaded on load
//   inc        : increment, saturating at MAX
//   term       : terminal value compared against the current count
//   tc_c       : combinational, count == term
module usb_tx_bitcnt #(
  parameter int unsigned MAX = 15,
  localparam int unsigned W  = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         tc_c
);

  logic [W-1:0] cnt_q;

  // Count register: load wins over increment; increment stops at MAX.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (inc && (cnt_q != W'(MAX))) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tc_c = (cnt_q == term);

endmodule

// File: rtl/usb_tx_line_encoder.sv
// USB full-/low-speed transmit line encoder: NRZI encoding, inline bit
// stuffing, configurable-length EOP, registered D+/D- drive.
// Optional build macro: USB_TX_ABORT_EN (adds tx_abort; forced stuff error
// followed by a normal EOP).
// Ports:
//   clk, n_rst   : clock, async active-low reset
//   bit_strobe   : one-cycle pulse per bit time
//   tx_start     : begin packet; also the strobe for the first bit
//   tx_data      : serial data bit (1 = no transition)
//   send_eop     : end packet after the current bit
//   tx_abort     : (USB_TX_ABORT_EN only) abort packet with a stuff error
//   dplus/dminus : registered line drive
//   data_take    : comb, tx_data consumed this cycle
//   stuff_active : comb, stuffed bit emitted this cycle
//   busy         : encoder not idle
//   eop_done     : comb, end of the last EOP J bit
module usb_tx_line_encoder
  import usb_tx_pkg::*;
#(
  parameter bit          LOW_SPEED    = 1'b0,
  parameter int unsigned STUFF_LEN    = 6,
  parameter int unsigned EOP_SE0_BITS = 2,
  parameter int unsigned EOP_J_BITS   = 1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic bit_strobe,
  input  logic tx_start,
  input  logic tx_data,
  input  logic send_eop,
`ifdef USB_TX_ABORT_EN
  input  logic tx_abort,
`endif
  output logic dplus,
  output logic dminus,
  output logic data_take,
  output logic stuff_active,
  output logic busy,
  output logic eop_done
);

  localparam int unsigned OW     = $clog2(STUFF_LEN + 1);
  localparam int unsigned BC_MAX = (EOP_SE0_BITS > EOP_J_BITS) ? EOP_SE0_BITS : EOP_J_BITS;
  localparam int unsigned BW     = $clog2(BC_MAX + 1);
  localparam logic [1:0]  LINE_J = LOW_SPEED ? J_LS : J_FS;
  localparam logic [1:0]  LINE_K = LOW_SPEED ? K_LS : K_FS;

  if ((STUFF_LEN < STUFF_LEN_MIN) || (STUFF_LEN > STUFF_LEN_MAX)) begin : g_bad_stuff_len
    $error("STUFF_LEN out of range");
  end
  if ((EOP_SE0_BITS < EOP_SE0_BITS_MIN) || (EOP_SE0_BITS > EOP_SE0_BITS_MAX)) begin : g_bad_se0
    $error("EOP_SE0_BITS out of range");
  end
  if ((EOP_J_BITS < EOP_J_BITS_MIN) || (EOP_J_BITS > EOP_J_BITS_MAX)) begin : g_bad_j
    $error("EOP_J_BITS out of range");
  end

  tx_state_e  state_q, state_d;
  logic [1:0] line_q, line_d;
  logic       eop_pend_q, eop_pend_d;

  logic          ones_load, ones_inc, ones_tc;
  logic          bit_load, bit_inc, bit_tc;
  logic [BW-1:0] bit_term;

  // Consecutive-ones count for stuffing.
  usb_tx_bitcnt #(.MAX(STUFF_LEN)) u_ones_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (ones_load),
    .load_val (OW'(0)),
    .inc      (ones_inc),
    .term     (OW'(STUFF_LEN)),
    .tc_c     (ones_tc)
  );

  // Bit-time count within the SE0 and J phases of the EOP.
  usb_tx_bitcnt #(.MAX(BC_MAX)) u_bit_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (bit_load),
    .load_val (BW'(1)),
    .inc      (bit_inc),
    .term     (bit_term),
    .tc_c     (bit_tc)
  );

  assign bit_term = (state_q == ST_EOPJ) ? BW'(EOP_J_BITS) : BW'(EOP_SE0_BITS);

`ifdef USB_TX_ABORT_EN
  localparam int unsigned AB_MAX = STUFF_LEN + 1;
  localparam int unsigned AW     = $clog2(AB_MAX + 1);

  logic abort_pend_q, abort_pend_d;
  logic abort_act_q, abort_act_d;
  logic abort_load, abort_inc, abort_tc;

  // Length of the forced no-transition run.
  usb_tx_bitcnt #(.MAX(AB_MAX)) u_abort_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (abort_load),
    .load_val (AW'(1)),
    .inc      (abort_inc),
    .term     (AW'(AB_MAX)),
    .tc_c     (abort_tc)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      abort_pend_q <= 1'b0;
      abort_act_q  <= 1'b0;
    end else begin
      abort_pend_q <= abort_pend_d;
      abort_act_q  <= abort_act_d;
    end
  end
`endif

  // State, line and pending-EOP registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      line_q     <= LINE_J;
      eop_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      eop_pend_q <= eop_pend_d;
    end
  end

  // Next state, next line level and per-bit strobes.
  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    eop_pend_d   = eop_pend_q;
    data_take    = 1'b0;
    stuff_active = 1'b0;
    eop_done     = 1'b0;
    ones_load    = 1'b0;
    ones_inc     = 1'b0;
    bit_load     = 1'b0;
    bit_inc      = 1'b0;
`ifdef USB_TX_ABORT_EN
    abort_pend_d = abort_pend_q;
    abort_act_d  = abort_act_q;
    abort_load   = 1'b0;
    abort_inc    = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        line_d = LINE_J;
        if (tx_start) begin
          ones_load = 1'b1;
          data_take = 1'b1;
          line_d    = tx_data ? LINE_J : LINE_K;
          state_d   = ST_DATA;
`ifdef USB_TX_ABORT_EN
          abort_pend_d = 1'b0;
          abort_act_d  = 1'b0;
`endif
        end
      end

      ST_DATA: begin
        if (send_eop) begin
          eop_pend_d = 1'b1;
        end
`ifdef USB_TX_ABORT_EN
        if (tx_abort && !abort_act_q) begin
          abort_pend_d = 1'b1;
        end
`endif
        if (bit_strobe) begin
`ifdef USB_TX_ABORT_EN
          // Abort run: hold the line with stuffing suppressed, then EOP.
          if (abort_act_q) begin
            if (abort_tc) begin
              line_d      = SE0;
              bit_load    = 1'b1;
              eop_pend_d  = 1'b0;
              abort_act_d = 1'b0;
              state_d     = ST_SE0;
            end else begin
              abort_inc = 1'b1;
            end
          end else if (abort_pend_q) begin
            abort_pend_d = 1'b0;
            abort_act_d  = 1'b1;
            abort_load   = 1'b1;
            ones_load    = 1'b1;
          end else
`endif
          // A due stuff bit goes out before the EOP.
          if (ones_tc) begin
            line_d       = line_toggle(line_q, LOW_SPEED);
            stuff_active = 1'b1;
            ones_load    = 1'b1;
          end else if (eop_pend_q) begin
            line_d     = SE0;
            bit_load   = 1'b1;
            eop_pend_d = 1'b0;
            state_d    = ST_SE0;
          end else begin
            data_take = 1'b1;
            if (tx_data) begin
              ones_inc = 1'b1;
            end else begin
              line_d    = line_toggle(line_q, LOW_SPEED);
              ones_load = 1'b1;
            end
          end
        end
      end

      ST_SE0: begin
        if (bit_strobe) begin
          if (bit_tc) begin
            line_d   = LINE_J;
            bit_load = 1'b1;
            state_d  = ST_EOPJ;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end

      ST_EOPJ: begin
        if (bit_strobe) begin
          if (bit_tc) begin
            eop_done = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        line_d  = LINE_J;
      end
    endcase
  end

  assign dplus  = line_q[1];
  assign dminus = line_q[0];
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Directed bench for usb_tx_line_encoder: a full-speed default instance
// (dut0) and a low-speed, 3-bit-SE0 instance (dut1) sharing stimulus.
module tb_usb_tx_line_encoder;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic bit_strobe = 1'b0;
  logic tx_start = 1'b0;
  logic tx_data = 1'b0;
  logic send_eop = 1'b0;
`ifdef USB_TX_ABORT_EN
  logic tx_abort = 1'b0;
`endif

  logic dp0, dm0, take0, stuff0, busy0, done0;
  logic dp1, dm1, take1, stuff1, busy1, done1;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] FJ = 2'b10;
  localparam logic [1:0] FK = 2'b01;
  localparam logic [1:0] LJ = 2'b01;
  localparam logic [1:0] Z  = 2'b00;

  always #5 clk = ~clk;

  usb_tx_line_encoder dut0 (
    .clk          (clk),
    .n_rst        (n_rst),
    .bit_strobe   (bit_strobe),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .send_eop     (send_eop),
`ifdef USB_TX_ABORT_EN
    .tx_abort     (tx_abort),
`endif
    .dplus        (dp0),
    .dminus       (dm0),
    .data_take    (take0),
    .stuff_active (stuff0),
    .busy         (busy0),
    .eop_done     (done0)
  );

  usb_tx_line_encoder #(.LOW_SPEED(1'b1), .EOP_SE0_BITS(3)) dut1 (
    .clk          (clk),
    .n_rst        (n_rst),
    .bit_strobe   (bit_strobe),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .send_eop     (send_eop),
`ifdef USB_TX_ABORT_EN
    .tx_abort     (tx_abort),
`endif
    .dplus        (dp1),
    .dminus       (dm1),
    .data_take    (take1),
    .stuff_active (stuff1),
    .busy         (busy1),
    .eop_done     (done1)
  );

  typedef struct {
    logic       st, sb, d, eop;
    logic       take, stuff, done;
    logic [1:0] line;
    logic       busy;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic sb, input logic d, input logic eop,
                              input logic take, input logic stuff, input logic done,
                              input logic [1:0] line, input logic busy);
    vec_t v;
    v.st = st; v.sb = sb; v.d = d; v.eop = eop;
    v.take = take; v.stuff = stuff; v.done = done;
    v.line = line; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %b want %b", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check comb pulses mid-cycle and the
  // registered line/busy after the following clock edge.
  task automatic run(input vec_t v, input int which, input int idx);
    @(negedge clk);
    tx_start = v.st; bit_strobe = v.sb; tx_data = v.d; send_eop = v.eop;
    #1;
    if (which == 0) begin
      chk("take0", idx, {1'b0, take0}, {1'b0, v.take});
      chk("stuff0", idx, {1'b0, stuff0}, {1'b0, v.stuff});
      chk("done0", idx, {1'b0, done0}, {1'b0, v.done});
    end else begin
      chk("take1", idx, {1'b0, take1}, {1'b0, v.take});
      chk("stuff1", idx, {1'b0, stuff1}, {1'b0, v.stuff});
      chk("done1", idx, {1'b0, done1}, {1'b0, v.done});
    end
    @(posedge clk);
    #1;
    if (which == 0) begin
      chk("line0", idx, {dp0, dm0}, v.line);
      chk("busy0", idx, {1'b0, busy0}, {1'b0, v.busy});
    end else begin
      chk("line1", idx, {dp1, dm1}, v.line);
      chk("busy1", idx, {1'b0, busy1}, {1'b0, v.busy});
    end
  endtask

  vec_t fs_tbl[$];
  vec_t ls_tbl[$];

  initial begin
    // Full-speed packets:        st sb d eop take stuff done line busy
    fs_tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, FK, 1));  // start, data 0 toggles
    fs_tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, FK, 1));  // no strobe: hold
    for (int i = 0; i < 6; i++)
      fs_tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, FK, 1));  // ones 1..6
    fs_tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, FJ, 1));  // stuffed 0
    fs_tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, FK, 1));  // data again
    fs_tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, FK, 1));  // send_eop, ones=0
    fs_tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, Z,  1));  // SE0 bit 1
    fs_tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, Z,  1));  // hold
    fs_tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, Z,  1));  // SE0 bit 2
    fs_tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, FJ, 1));  // J
    fs_tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, FJ, 0));  // eop_done
    fs_tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, FJ, 0));  // strobe/eop ignored in idle
    fs_tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, FJ, 1));  // start, data 1 holds
    fs_tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, FJ, 1));  // tx_start ignored in DATA
    for (int i = 0; i < 6; i++)
      fs_tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, FJ, 1));  // strobes 1-6 hold
    fs_tbl.push_back(mk(0, 1, 1, 1, 0, 1, 0, FK, 1));  // stuff before EOP
    fs_tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, Z,  1));
    fs_tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, Z,  1));
    fs_tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, FJ, 1));
    fs_tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, FJ, 0));
    fs_tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, FJ, 1));  // start
    fs_tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, FK, 1));  // eop with strobe: data first
    fs_tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, Z,  1));
    fs_tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, Z,  1));
    fs_tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, Z,  1));
    fs_tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, FJ, 1));
    fs_tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, FJ, 0));

    // Low-speed, 3 SE0 bits.
    ls_tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, LJ, 1));
    ls_tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, LJ, 1));
    ls_tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, Z,  1));
    ls_tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, Z,  1));
    ls_tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, Z,  1));
    ls_tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, LJ, 1));
    ls_tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, LJ, 0));

    // Reset values.
    #12;
    chk("rst_line0", 0, {dp0, dm0}, FJ);
    chk("rst_busy0", 0, {1'b0, busy0}, 2'b00);
    chk("rst_take0", 0, {1'b0, take0}, 2'b00);
    chk("rst_line1", 0, {dp1, dm1}, LJ);
    @(negedge clk);
    n_rst = 1'b1;

    foreach (fs_tbl[i]) run(fs_tbl[i], 0, i);

    // Fresh reset, then the low-speed instance.
    @(negedge clk);
    tx_start = 1'b0; bit_strobe = 1'b0; send_eop = 1'b0;
    n_rst = 1'b0;
    #1;
    chk("rst2_line1", 0, {dp1, dm1}, LJ);
    chk("rst2_busy1", 0, {1'b0, busy1}, 2'b00);
    @(negedge clk);
    n_rst = 1'b1;
    foreach (ls_tbl[i]) run(ls_tbl[i], 1, i);

    // Reset asserted in the middle of SE0.
    run(mk(1, 0, 1, 0, 1, 0, 0, FJ, 1), 0, 100);
    run(mk(0, 1, 1, 1, 1, 0, 0, FJ, 1), 0, 101);
    run(mk(0, 1, 0, 0, 0, 0, 0, Z,  1), 0, 102);
    @(negedge clk);
    bit_strobe = 1'b1;
    #2;
    n_rst = 1'b0;
    #1;
    chk("midrst_line0", 0, {dp0, dm0}, FJ);
    chk("midrst_busy0", 0, {1'b0, busy0}, 2'b00);
    chk("midrst_done0", 0, {1'b0, done0}, 2'b00);
    @(posedge clk);
    #1;
    chk("midrst_done0b", 1, {1'b0, done0}, 2'b00);
    chk("midrst_line0b", 1, {dp0, dm0}, FJ);
    @(negedge clk);
    bit_strobe = 1'b0;
    n_rst = 1'b1;
    run(mk(1, 0, 0, 0, 1, 0, 0, FK, 1), 0, 103);
    run(mk(0, 1, 1, 0, 1, 0, 0, FK, 1), 0, 104);

    @(negedge clk);
    tx_start = 1'b0; bit_strobe = 1'b0; send_eop = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
